// File: rtl/rect_plot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rect_plot_pkg
//  Description : Shared definitions for the rectangle plotter: FSM state
//                encoding, default visible screen extent and a helper that
//                sizes sweep counters.
//                Optional macro RECT_PLOT_CLEAR_EN adds the CLEAR state.
//  Revision    : 1.0 - initial release
// ============================================================================
package rect_plot_pkg;

    // Default visible pixel extent of the VGA adapter.
    localparam int c_SCREEN_W_DEFAULT = 160;
    localparam int c_SCREEN_H_DEFAULT = 120;

    // Operator-driven load sequence followed by the pixel sweeps.
    typedef enum logic [3:0] {
        ST_LOAD_X       = 4'd0,
        ST_LOAD_X_WAIT  = 4'd1,
        ST_LOAD_Y       = 4'd2,
        ST_LOAD_Y_WAIT  = 4'd3,
        ST_LOAD_COL     = 4'd4,
        ST_LOAD_COL_WAIT= 4'd5,
        ST_DRAW         = 4'd6
`ifdef RECT_PLOT_CLEAR_EN
        ,
        ST_CLEAR        = 4'd7
`endif
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int fn_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rect_plot_pkg
`default_nettype wire

// File: rtl/rect_plot_raster.sv
`default_nettype none
// ============================================================================
//  Module      : rect_plot_raster
//  Description : Two-dimensional wrap counter. cx runs 0..LIM_X-1 (inner),
//                cy runs 0..LIM_Y-1 (outer). Advances one step per cycle
//                while en is high and wraps both to zero after the last cell.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                en    - advance one cell
//                clr   - force both counters to zero (beats en)
//                cx/cy - current cell
//                last  - current cell is (LIM_X-1, LIM_Y-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_plot_raster
    import rect_plot_pkg::*;
#(
    parameter int LIM_X  = 4,
    parameter int LIM_Y  = 4,
    parameter int CNT_XW = fn_cnt_w(LIM_X),
    parameter int CNT_YW = fn_cnt_w(LIM_Y)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    output logic [CNT_XW-1:0] cx,
    output logic [CNT_YW-1:0] cy,
    output logic              last
);

    localparam logic [CNT_XW-1:0] c_X_MAX = CNT_XW'(LIM_X - 1);
    localparam logic [CNT_YW-1:0] c_Y_MAX = CNT_YW'(LIM_Y - 1);

    logic [CNT_XW-1:0] r_cx;
    logic [CNT_YW-1:0] r_cy;
    logic              w_x_end;
    logic              w_y_end;

    assign w_x_end = (r_cx == c_X_MAX);
    assign w_y_end = (r_cy == c_Y_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (en) begin
            if (w_x_end) begin
                r_cx <= '0;
                r_cy <= w_y_end ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    assign cx   = r_cx;
    assign cy   = r_cy;
    assign last = w_x_end && w_y_end;

endmodule : rect_plot_raster
`default_nettype wire

// File: rtl/rect_plot_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rect_plot_fsm
//  Description : Operator-driven rectangle plotter. x, y and colour are
//                loaded with press/release of go, then a BOX_W x BOX_H
//                rectangle is swept one pixel per cycle, clipped to the
//                visible screen. Optionally black clears the whole screen.
//  Config      : `define RECT_PLOT_CLEAR_EN to enable black / CLEAR sweep.
//  Ports       : clk        - clock, rising edge
//                reset      - synchronous active-high reset
//                go         - operator key (level, high = pressed)
//                black      - clear-screen request (level)
//                data_in    - shared x / y switches (y uses low Y_W bits)
//                colour_in  - colour switches
//                x_out/y_out/colour_out - pixel address and colour
//                plot       - pixel write enable
//                busy       - sweep in progress
//                done       - pulse on the last sweep cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_plot_fsm
    import rect_plot_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int BOX_W    = 4,
    parameter int BOX_H    = 4,
    parameter int SCREEN_W = c_SCREEN_W_DEFAULT,
    parameter int SCREEN_H = c_SCREEN_H_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             black,
    input  logic [X_W-1:0]   data_in,
    input  logic [COL_W-1:0] colour_in,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [COL_W-1:0] colour_out,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam int c_BXW = fn_cnt_w(BOX_W);
    localparam int c_BYW = fn_cnt_w(BOX_H);

    state_t           r_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [COL_W-1:0] r_col;

    logic             w_black;

    // ------------------------------------------------------------------
    // Box sweep counter; held at zero whenever not drawing so every DRAW
    // starts at the rectangle's top-left corner.
    // ------------------------------------------------------------------
    logic [c_BXW-1:0] w_bcx;
    logic [c_BYW-1:0] w_bcy;
    logic             w_box_last;
    logic             w_box_en;

    assign w_box_en = (r_state == ST_DRAW);

    rect_plot_raster #(
        .LIM_X (BOX_W),
        .LIM_Y (BOX_H)
    ) u_box (
        .clk   (clk),
        .reset (reset),
        .en    (w_box_en),
        .clr   (!w_box_en),
        .cx    (w_bcx),
        .cy    (w_bcy),
        .last  (w_box_last)
    );

    // Pixel address is formed one bit wider so that an off-screen pixel
    // is detected before it would wrap back onto the visible area.
    logic [X_W:0] w_px;
    logic [Y_W:0] w_py;
    logic         w_in_view;

    assign w_px      = {1'b0, r_x} + (X_W+1)'(w_bcx);
    assign w_py      = {1'b0, r_y} + (Y_W+1)'(w_bcy);
    assign w_in_view = (w_px < (X_W+1)'(SCREEN_W)) && (w_py < (Y_W+1)'(SCREEN_H));

`ifdef RECT_PLOT_CLEAR_EN
    localparam int c_SXW = fn_cnt_w(SCREEN_W);
    localparam int c_SYW = fn_cnt_w(SCREEN_H);

    logic [c_SXW-1:0] w_scx;
    logic [c_SYW-1:0] w_scy;
    logic             w_scr_last;
    logic             w_scr_en;

    assign w_black  = black;
    assign w_scr_en = (r_state == ST_CLEAR);

    rect_plot_raster #(
        .LIM_X (SCREEN_W),
        .LIM_Y (SCREEN_H)
    ) u_screen (
        .clk   (clk),
        .reset (reset),
        .en    (w_scr_en),
        .clr   (!w_scr_en),
        .cx    (w_scx),
        .cy    (w_scy),
        .last  (w_scr_last)
    );
`else
    // Without the clear feature the request line is accepted but unused.
    logic w_unused_black;
    assign w_unused_black = black;
    assign w_black        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM. A clear request pre-empts any load step; DRAW and
    // CLEAR run to completion regardless of go/black.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD_X;
            r_x     <= '0;
            r_y     <= '0;
            r_col   <= '0;
        end else begin
            case (r_state)
                ST_LOAD_X: begin
                    r_x <= data_in;
                    if (w_black)  r_state <= next_clear();
                    else if (go)  r_state <= ST_LOAD_X_WAIT;
                end
                ST_LOAD_X_WAIT: begin
                    if (w_black)  r_state <= next_clear();
                    else if (!go) r_state <= ST_LOAD_Y;
                end
                ST_LOAD_Y: begin
                    r_y <= data_in[Y_W-1:0];
                    if (w_black)  r_state <= next_clear();
                    else if (go)  r_state <= ST_LOAD_Y_WAIT;
                end
                ST_LOAD_Y_WAIT: begin
                    if (w_black)  r_state <= next_clear();
                    else if (!go) r_state <= ST_LOAD_COL;
                end
                ST_LOAD_COL: begin
                    r_col <= colour_in;
                    if (w_black)  r_state <= next_clear();
                    else if (go)  r_state <= ST_LOAD_COL_WAIT;
                end
                ST_LOAD_COL_WAIT: begin
                    if (w_black)  r_state <= next_clear();
                    else if (!go) r_state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (w_box_last) r_state <= ST_LOAD_X;
                end
`ifdef RECT_PLOT_CLEAR_EN
                ST_CLEAR: begin
                    if (w_scr_last) r_state <= ST_LOAD_X;
                end
`endif
                default: r_state <= ST_LOAD_X;
            endcase
        end
    end

    // Destination of a clear request; only reachable when w_black can be 1.
    function automatic state_t next_clear();
`ifdef RECT_PLOT_CLEAR_EN
        return ST_CLEAR;
`else
        return ST_LOAD_X;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Outputs decode purely from registered state and counters.
    // ------------------------------------------------------------------
    always_comb begin
        x_out      = r_x;
        y_out      = r_y;
        colour_out = r_col;
        plot       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_DRAW: begin
                x_out      = w_px[X_W-1:0];
                y_out      = w_py[Y_W-1:0];
                colour_out = r_col;
                plot       = w_in_view;
                busy       = 1'b1;
                done       = w_box_last;
            end
`ifdef RECT_PLOT_CLEAR_EN
            ST_CLEAR: begin
                x_out      = X_W'(w_scx);
                y_out      = Y_W'(w_scy);
                colour_out = '0;
                plot       = 1'b1;
                busy       = 1'b1;
                done       = w_scr_last;
            end
`endif
            default: ;
        endcase
    end

endmodule : rect_plot_fsm
`default_nettype wire

// File: tb/tb_rect_plot_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_plot_fsm
//  Description : Directed self-checking bench for rect_plot_fsm (default
//                parameters) plus a 1x1 box instance sharing the stimulus.
//                Honours RECT_PLOT_CLEAR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_plot_fsm;

    logic       clk;
    logic       r_reset;
    logic       r_go;
    logic       r_black;
    logic [7:0] r_data;
    logic [2:0] r_colour;

    logic [7:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_col;
    logic       w_plot, w_busy, w_done;

    logic [7:0] w1_x;
    logic [6:0] w1_y;
    logic [2:0] w1_col;
    logic       w1_plot, w1_busy, w1_done;

    int n_pass  = 0;
    int n_total = 0;

    rect_plot_fsm u_dut (
        .clk        (clk),
        .reset      (r_reset),
        .go         (r_go),
        .black      (r_black),
        .data_in    (r_data),
        .colour_in  (r_colour),
        .x_out      (w_x),
        .y_out      (w_y),
        .colour_out (w_col),
        .plot       (w_plot),
        .busy       (w_busy),
        .done       (w_done)
    );

    rect_plot_fsm #(.BOX_W(1), .BOX_H(1)) u_dut1 (
        .clk        (clk),
        .reset      (r_reset),
        .go         (r_go),
        .black      (r_black),
        .data_in    (r_data),
        .colour_in  (r_colour),
        .x_out      (w1_x),
        .y_out      (w1_y),
        .colour_out (w1_col),
        .plot       (w1_plot),
        .busy       (w1_busy),
        .done       (w1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag, input int ex, input int ey, input int ec);
        check({tag, "_plot"}, 32'(w_plot), 0);
        check({tag, "_busy"}, 32'(w_busy), 0);
        check({tag, "_done"}, 32'(w_done), 0);
        check({tag, "_x"},    32'(w_x), 32'(ex));
        check({tag, "_y"},    32'(w_y), 32'(ey));
        check({tag, "_col"},  32'(w_col), 32'(ec));
    endtask

    // go press/release sequence for x, y and colour; ends in first DRAW cycle.
    task automatic load(input int x, input int y, input int col);
        r_data = 8'(x); r_go = 1'b0; step();
        check("load_x_out", 32'(w_x), 32'(x));
        r_go = 1'b1; step();
        r_go = 1'b0; step();
        r_data = 8'(y); step();
        r_go = 1'b1; step();
        r_go = 1'b0; step();
        r_colour = 3'(col); step();
        r_go = 1'b1; step();
        r_go = 1'b0; step();
    endtask

    // 4x4 default box: expected pixel stream computed from the corner.
    task automatic check_draw(input int x0, input int y0, input int col,
                              input bit chk_small, output int n_plotted);
        int k;
        k = 0;
        n_plotted = 0;
        for (int cy = 0; cy < 4; cy++) begin
            for (int cx = 0; cx < 4; cx++) begin
                int px;
                int py;
                bit ep;
                px = x0 + cx;
                py = y0 + cy;
                ep = (px < 160) && (py < 120);
                check("draw_busy", 32'(w_busy), 1);
                check("draw_plot", 32'(w_plot), 32'(ep));
                check("draw_x",    32'(w_x), 32'(px & 255));
                check("draw_y",    32'(w_y), 32'(py & 127));
                check("draw_col",  32'(w_col), 32'(col));
                check("draw_done", 32'(w_done), 32'(k == 15));
                if (chk_small && k == 1) begin
                    check("box1_after_busy", 32'(w1_busy), 0);
                    check("box1_after_plot", 32'(w1_plot), 0);
                    check("box1_after_done", 32'(w1_done), 0);
                end
                n_plotted += int'(w_plot);
                k++;
                step();
            end
        end
    endtask

    initial begin
        int np;
        r_reset = 1'b1; r_go = 1'b0; r_black = 1'b0;
        r_data = 8'd0; r_colour = 3'd0;
        step(); step();
        check_idle("reset", 0, 0, 0);
        r_reset = 1'b0;

        // Basic draw at (10,20) colour 3; 1x1 instance plots once with done.
        load(10, 20, 3);
        check("box1_plot", 32'(w1_plot), 1);
        check("box1_done", 32'(w1_done), 1);
        check("box1_busy", 32'(w1_busy), 1);
        check("box1_x",    32'(w1_x), 10);
        check("box1_y",    32'(w1_y), 20);
        check("box1_col",  32'(w1_col), 3);
        check_draw(10, 20, 3, 1'b1, np);
        check("draw1_count", 32'(np), 16);
        check_idle("after_draw1", 10, 20, 3);

        // Bottom-right corner clipping.
        load(158, 118, 5);
        check_draw(158, 118, 5, 1'b0, np);
        check("clip_count", 32'(np), 4);
        check_idle("after_clip", 158, 118, 5);

        // go held high across the whole sweep.
        load(1, 2, 7);
        r_go = 1'b1;
        check_draw(1, 2, 7, 1'b0, np);
        check("gohold_count", 32'(np), 16);
        check("gohold_idle", 32'(w_busy), 0);
        r_data = 8'd40; step();
        check("gohold_xcap", 32'(w_x), 40);
        r_data = 8'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gohold_wait_x", 32'(w_x), 40);
            check("gohold_wait_busy", 32'(w_busy), 0);
        end
        r_go = 1'b0; step();
        step();
        check("gohold_ycap", 32'(w_y), 77);

        // Reset in the middle of a sweep.
        r_reset = 1'b1; step(); r_reset = 1'b0;
        load(10, 20, 3);
        for (int i = 0; i < 4; i++) step();
        check("middraw_busy", 32'(w_busy), 1);
        r_data = 8'd0;
        r_reset = 1'b1; step();
        check_idle("midreset", 0, 0, 0);
        r_reset = 1'b0; step();
        check_idle("midreset_post", 0, 0, 0);

        // Clear request while in LOAD_Y.
        r_data = 8'd10; step();
        r_go = 1'b1; step();
        r_go = 1'b0; step();
        r_data = 8'd33; r_black = 1'b1; step();
        r_black = 1'b0;
`ifdef RECT_PLOT_CLEAR_EN
        for (int i = 0; i < 19200; i++) begin
            check("clear_px",
                  {14'd0, w_plot, w_busy, w_done, w_col, w_x, w_y},
                  {14'd0, 1'b1, 1'b1, (i == 19199), 3'd0, 8'(i % 160), 7'(i / 160)});
            step();
        end
        check_idle("after_clear", 10, 33, 0);
`else
        r_black = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_idle("black_ignored", 10, 33, 0);
            step();
        end
        r_black = 1'b0;
        check_idle("black_ignored_end", 10, 33, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rect_plot_fsm
`default_nettype wire

// File: doc/rect_plot_fsm.md
RECT_PLOT_FSM -- requirements
Module: rect_plot_fsm

Interface
REQ-001 Parameter X_W, default 8, x coordinate width.
REQ-002 Parameter Y_W, default 7, y coordinate width.
REQ-003 Parameter COL_W, default 3, colour width.
REQ-004 Parameter BOX_W, default 4, rectangle width in pixels (1..2**X_W).
REQ-005 Parameter BOX_H, default 4, rectangle height in pixels (1..2**Y_W).
REQ-006 Parameters SCREEN_W, default 160, and SCREEN_H, default 120, visible pixel extent.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 go  input  1  level operator key, pressed high.
REQ-010 black  input  1  level request to clear the screen.
REQ-011 data_in  input  X_W  shared coordinate switches; low Y_W bits are used for y.
REQ-012 colour_in  input  COL_W  colour switches.
REQ-013 x_out  output  X_W; y_out  output  Y_W; colour_out  output  COL_W  pixel address and colour to VGA adapter.
REQ-014 plot  output  1  pixel write enable, qualifies x_out/y_out/colour_out in the same cycle.
REQ-015 busy  output  1  high in DRAW and CLEAR.
REQ-016 done  output  1  one-cycle pulse on the final cycle of DRAW or CLEAR.

Function
REQ-017 States: LOAD_X, LOAD_X_WAIT, LOAD_Y, LOAD_Y_WAIT, LOAD_COL, LOAD_COL_WAIT, DRAW, CLEAR.
REQ-018 LOAD_n -> LOAD_n_WAIT when go=1; LOAD_n_WAIT -> next load state when go=0; LOAD_COL_WAIT with go=0 -> DRAW.
REQ-019 x_reg captures data_in each cycle in LOAD_X; y_reg captures data_in[Y_W-1:0] in LOAD_Y; col_reg captures colour_in in LOAD_COL.
REQ-020 DRAW raster: cx inner 0..BOX_W-1, cy outer 0..BOX_H-1, one pixel per cycle, exactly BOX_W*BOX_H cycles, then -> LOAD_X.
REQ-021 In DRAW: x_out=x_reg+cx, y_out=y_reg+cy, computed at X_W+1 / Y_W+1 bits, colour_out=col_reg.
REQ-022 Clipping: plot=0 for a pixel whose unwrapped x >= SCREEN_W or y >= SCREEN_H; counters still advance, cycle count unchanged.
REQ-023 go is ignored in DRAW and CLEAR; releasing or pressing it never shortens or extends a sweep.
REQ-024 black=1 in any LOAD_* or LOAD_*_WAIT state -> CLEAR next cycle; black is ignored in DRAW and CLEAR.
REQ-025 CLEAR sweeps x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer, colour_out=0, plot=1 every cycle, SCREEN_W*SCREEN_H cycles, then -> LOAD_X; x_reg/y_reg/col_reg unchanged.
REQ-026 Outside DRAW/CLEAR: plot=0, done=0, busy=0, x_out=x_reg, y_out=y_reg, colour_out=col_reg.
REQ-027 done=1 exactly on the cycle that plots (or clips) the last pixel.

Reset
REQ-028 reset=1 at a clock edge forces LOAD_X, counters 0, x_reg/y_reg/col_reg 0, from any state including mid-DRAW/CLEAR.
REQ-029 From the first cycle after reset: plot=0, busy=0, done=0, x_out=0, y_out=0, colour_out=0.

Configuration
REQ-030 Macro RECT_PLOT_CLEAR_EN defined: black and CLEAR behave per REQ-024/025.
REQ-031 Macro undefined: CLEAR state and its counter are absent, black is ignored, all other behaviour identical.

Structure
REQ-032 Package rect_plot_pkg holds the state enumeration and default SCREEN_W/SCREEN_H constants.
REQ-033 Sub-module rect_plot_raster: parametrised 2D wrap counter (limits, enable, clear, last flag), instantiated for the box sweep and, under RECT_PLOT_CLEAR_EN, for the screen sweep.

Verification
REQ-034 Defaults; load x=10, y=20, col=3 via go press/release -> 16 cycles plot=1, pixels (10..13,20..23) row-major, done on 16th, then LOAD_X.
REQ-035 x=158, y=118, BOX 4x4 -> 16 busy cycles, plot=1 only for x 158..159 and y 118..119 (4 pixels), done on 16th.
REQ-036 go held high through entire DRAW -> sweep length unchanged; FSM waits in LOAD_X_WAIT until go=0.
REQ-037 reset asserted on cycle 5 of DRAW -> next cycle plot=0, busy=0, outputs 0, state LOAD_X.
REQ-038 RECT_PLOT_CLEAR_EN, black=1 in LOAD_Y -> 19200 cycles plot=1, colour_out=0, last pixel (159,119) with done; without macro, black has no effect.
REQ-039 BOX_W=1, BOX_H=1 -> single plot cycle with done=1 in that cycle.
